// File: rtl/partselect_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : partselect_scan_pkg
//  Description : Shared defaults, derived limits and FSM state type for the
//                part-select index sweep sequencer.
//  Contents    : DEF_DATA_W / DEF_WIN_W / DEF_IDX_W  default widths
//                MAX_IDX                             last legal window index
//                calc_max_idx()                      MAX_IDX for any widths
//                scan_state_e                        {ST_IDLE, ST_SCAN}
//  Revision    : 1.0  initial release
// ============================================================================
package partselect_scan_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_WIN_W  = 3;
   localparam int DEF_IDX_W  = 4;

   // Highest index whose WIN_W-bit window still lies inside the data word.
   localparam int MAX_IDX = DEF_DATA_W - DEF_WIN_W;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_e;

   function automatic int calc_max_idx(input int data_w, input int win_w);
      return data_w - win_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/partselect_scan_seq_pick.sv
`default_nettype none
// ============================================================================
//  Module      : bitwindow_pick
//  Description : Combinational window extractor, o_win = i_data[i_idx +: WIN_W].
//                The caller keeps i_idx within 0..DATA_W-WIN_W.
//  Ports       : i_data  [DATA_W-1:0]  word to read
//                i_idx   [IDX_W-1:0]   window start bit
//                o_win   [WIN_W-1:0]   selected window
//  Revision    : 1.0  initial release
// ============================================================================
module bitwindow_pick
   import partselect_scan_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int WIN_W  = DEF_WIN_W,
   parameter int IDX_W  = DEF_IDX_W
) (
   input  logic [DATA_W-1:0] i_data,
   input  logic [IDX_W-1:0]  i_idx,
   output logic [WIN_W-1:0]  o_win
);

   // A right shift never addresses bits outside the word, so the select is
   // well defined for every index value.
   logic [DATA_W-1:0] w_shifted;

   assign w_shifted = i_data >> i_idx;
   assign o_win     = w_shifted[WIN_W-1:0];

endmodule
`default_nettype wire

// File: rtl/partselect_scan_seq.sv
`default_nettype none
// ============================================================================
//  Module      : partselect_scan_seq
//  Description : Accepts {data, start, count} over valid/ready and emits one
//                beat per cycle carrying data[idx +: WIN_W] for consecutive
//                indices. Requests that run past the last legal index are
//                truncated and flagged with out_ovf.
//  Ports       : clk, rst_n (async, active low)
//                in_valid/in_ready, in_data, in_start, in_count  command side
//                out_valid/out_ready, out_idx, out_win, out_last,
//                out_ovf                                          beat side
//                busy                                             in SCAN
//  Revision    : 1.0  initial release
// ============================================================================
module partselect_scan_seq
   import partselect_scan_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int WIN_W  = DEF_WIN_W,
   parameter int IDX_W  = DEF_IDX_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [IDX_W-1:0]  in_start,
   input  logic [IDX_W-1:0]  in_count,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_idx,
   output logic [WIN_W-1:0]  out_win,
   output logic              out_last,
   output logic              out_ovf,
   output logic              busy
);

   localparam logic [IDX_W-1:0] c_max_idx = IDX_W'(calc_max_idx(DATA_W, WIN_W));
   localparam logic [IDX_W-1:0] c_one     = IDX_W'(1);

   scan_state_e       state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  rem_q, rem_d;
   logic              out_valid_q, out_valid_d;
   logic [IDX_W-1:0]  out_idx_q, out_idx_d;
   logic [WIN_W-1:0]  out_win_q, out_win_d;
   logic              out_last_q, out_last_d;
   logic              out_ovf_q, out_ovf_d;
   logic              busy_q, busy_d;

   logic              w_accept;
   logic              w_fire;
   logic              w_load;
   logic [IDX_W-1:0]  w_beat_idx;
   logic [IDX_W-1:0]  w_beat_rem;
   logic [DATA_W-1:0] w_beat_data;
   logic              w_in_range;
   logic [IDX_W-1:0]  w_pick_idx;
   logic [WIN_W-1:0]  w_win;

   assign in_ready = (state_q == ST_IDLE);
   assign w_accept = in_valid && in_ready;
   assign w_fire   = out_valid_q && out_ready;

   // The next beat is either the first beat of a fresh command (IDLE) or the
   // successor of the beat currently being handed off (SCAN).
   always_comb begin
      if (state_q == ST_IDLE) begin
         w_beat_idx  = in_start;
         w_beat_rem  = in_count;
         w_beat_data = in_data;
      end else begin
         w_beat_idx  = idx_q + c_one;
         w_beat_rem  = rem_q - c_one;
         w_beat_data = data_q;
      end
      w_in_range = (w_beat_idx <= c_max_idx);
      // Out-of-range starts never reach the picker; their window is forced to 0.
      w_pick_idx = w_in_range ? w_beat_idx : '0;
   end

   bitwindow_pick #(
      .DATA_W (DATA_W),
      .WIN_W  (WIN_W),
      .IDX_W  (IDX_W)
   ) u_pick (
      .i_data (w_beat_data),
      .i_idx  (w_pick_idx),
      .o_win  (w_win)
   );

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      idx_d       = idx_q;
      rem_d       = rem_q;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      out_win_d   = out_win_q;
      out_last_d  = out_last_q;
      out_ovf_d   = out_ovf_q;
      w_load      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               data_d = in_data;
               // A zero-length request is consumed without producing a beat.
               if (in_count != '0) begin
                  state_d = ST_SCAN;
                  w_load  = 1'b1;
               end
            end
         end
         ST_SCAN: begin
            if (w_fire) begin
               if (out_last_q) begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b0;
                  out_idx_d   = '0;
                  out_win_d   = '0;
                  out_last_d  = 1'b0;
                  out_ovf_d   = 1'b0;
               end else begin
                  w_load = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (w_load) begin
         idx_d       = w_beat_idx;
         rem_d       = w_beat_rem;
         out_valid_d = 1'b1;
         out_idx_d   = w_beat_idx;
         if (w_in_range) begin
            out_win_d  = w_win;
            out_last_d = (w_beat_rem == c_one) || (w_beat_idx == c_max_idx);
            // Hitting the top index with windows still owed means truncation.
            out_ovf_d  = (w_beat_idx == c_max_idx) && (w_beat_rem > c_one);
         end else begin
            out_win_d  = '0;
            out_last_d = 1'b1;
            out_ovf_d  = 1'b1;
         end
      end

      busy_d = (state_d == ST_SCAN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         data_q      <= '0;
         idx_q       <= '0;
         rem_q       <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_win_q   <= '0;
         out_last_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         idx_q       <= idx_d;
         rem_q       <= rem_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         out_win_q   <= out_win_d;
         out_last_q  <= out_last_d;
         out_ovf_q   <= out_ovf_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_win   = out_win_q;
   assign out_last  = out_last_q;
   assign out_ovf   = out_ovf_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire
